// File: rtl/trace_packet_arbiter_pkg.sv
// trace_pkt_defs: stream tags, config addresses and shared helpers for the trace packet arbiter.
package trace_pkt_defs;
  localparam logic [15:0] MARKER_TAG       = 16'hFFFF;
  localparam logic [15:0] ECHO_TAG         = 16'hFFFE;
  localparam logic [15:0] ADDR_OSC_RATE    = 16'h0000;
  localparam logic [15:0] ADDR_TRACE_FLAGS = 16'h0001;
  localparam logic [15:0] ADDR_ECHO        = 16'h0002;
  typedef enum logic [1:0] {GNT_NONE, GNT_TRACE, GNT_ECHO} grant_e;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/trace_packet_arbiter_if.sv
// trace_packet_arbiter_if: trace source, config bus and usb_comm packet signals of the arbiter.
interface trace_packet_arbiter_if #(parameter int DEPTH = 16);
  logic [31:0]              trace_data;
  logic                     trace_strobe;
  logic [15:0]              config_addr;
  logic [15:0]              config_data;
  logic                     config_strobe;
  logic                     out_ready;
  logic [31:0]              out_data;
  logic                     out_strobe;
  logic [$clog2(DEPTH):0]   fifo_level;
  logic [15:0]              drop_total;
  modport master (
    output trace_data, trace_strobe, config_addr, config_data, config_strobe, out_ready,
    input  out_data, out_strobe, fifo_level, drop_total
  );
  modport slave (
    input  trace_data, trace_strobe, config_addr, config_data, config_strobe, out_ready,
    output out_data, out_strobe, fifo_level, drop_total
  );
endinterface

// File: rtl/trace_packet_arbiter_fifo.sv
// trace_fifo: synchronous DEPTH x 32 FIFO with registered full/empty and no write-through.
module trace_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   mclk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [31:0]            data_i,
  output logic [31:0]            data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d, empty_q, empty_d, wr_en, rd_en;
  always_comb begin
    wr_en   = push_i && !full_q;
    rd_en   = pop_i && !empty_q;
    wr_d    = wr_q + AW'(wr_en);
    rd_d    = rd_q + AW'(rd_en);
    level_d = level_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    full_d  = level_d == (AW+1)'(DEPTH);
    empty_d = level_d == '0;
  end
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end
  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge mclk) begin
    if (wr_en) mem[wr_q] <= data_i;
  end
  assign data_o  = mem[rd_q];
  assign level_o = level_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/trace_packet_arbiter.sv
// trace_packet_arbiter: merges buffered trace words, drop markers and host echoes onto the usb_comm packet path.
module trace_packet_arbiter
  import trace_pkt_defs::*;
#(
  parameter int          DEPTH      = 16,
  parameter int          MAX_STREAK = 8,
  parameter logic [15:0] ECHO_ADDR  = ADDR_ECHO
) (
  input logic                   mclk,
  input logic                   reset_n,
  trace_packet_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_STREAK + 1);
  logic [31:0]            head, fifo_din, out_data_q, out_data_d;
  logic [$clog2(DEPTH):0] level;
  logic                   full, empty, push, pop, echo_req;
  logic                   out_strobe_q, out_strobe_d;
  logic                   drop_pending_q, drop_pending_d, echo_pending_q, echo_pending_d;
  logic [15:0]            drop_count_q, drop_count_d, drop_total_q, drop_total_d;
  logic [15:0]            echo_data_q, echo_data_d;
  logic [SW-1:0]          streak_q, streak_d;
  grant_e                 grant;
  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .mclk    (mclk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (fifo_din),
    .data_o  (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );
  // A pending marker takes the push slot first, so it lands exactly where the lost words were.
  always_comb begin
    push           = 1'b0;
    fifo_din       = bus.trace_data;
    drop_pending_d = drop_pending_q;
    drop_count_d   = drop_count_q;
    drop_total_d   = drop_total_q;
    if (drop_pending_q && !full) begin
      push           = 1'b1;
      fifo_din       = {MARKER_TAG, drop_count_q};
      drop_pending_d = bus.trace_strobe;
      drop_count_d   = {15'd0, bus.trace_strobe};
      drop_total_d   = bus.trace_strobe ? sat_inc(drop_total_q) : drop_total_q;
    end else if (bus.trace_strobe && full) begin
      drop_pending_d = 1'b1;
      drop_count_d   = sat_inc(drop_count_q);
      drop_total_d   = sat_inc(drop_total_q);
    end else begin
      push = bus.trace_strobe;
    end
  end
  always_comb begin
    echo_req       = bus.config_strobe && bus.config_addr == ECHO_ADDR;
    grant          = !bus.out_ready ? GNT_NONE :
                     (echo_pending_q && (empty || streak_q == SW'(MAX_STREAK))) ? GNT_ECHO :
                     !empty ? GNT_TRACE : GNT_NONE;
    pop            = grant == GNT_TRACE;
    streak_d       = !bus.out_ready ? streak_q :
                     !pop ? '0 :
                     streak_q == SW'(MAX_STREAK) ? streak_q : streak_q + SW'(1);
    echo_pending_d = echo_req || (echo_pending_q && grant != GNT_ECHO);
    echo_data_d    = echo_req ? bus.config_data : echo_data_q;
    out_data_d     = grant == GNT_ECHO ? {ECHO_TAG, echo_data_q} : pop ? head : out_data_q;
    out_strobe_d   = grant != GNT_NONE;
  end
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q     <= '0;
      out_strobe_q   <= 1'b0;
      drop_pending_q <= 1'b0;
      drop_count_q   <= '0;
      drop_total_q   <= '0;
      echo_pending_q <= 1'b0;
      echo_data_q    <= '0;
      streak_q       <= '0;
    end else begin
      out_data_q     <= out_data_d;
      out_strobe_q   <= out_strobe_d;
      drop_pending_q <= drop_pending_d;
      drop_count_q   <= drop_count_d;
      drop_total_q   <= drop_total_d;
      echo_pending_q <= echo_pending_d;
      echo_data_q    <= echo_data_d;
      streak_q       <= streak_d;
    end
  end
  assign bus.out_data   = out_data_q;
  assign bus.out_strobe = out_strobe_q;
  assign bus.fifo_level = level;
  assign bus.drop_total = drop_total_q;
endmodule

// File: tb/tb_trace_packet_arbiter.sv
// tb_trace_packet_arbiter: random and directed stimulus scored against a queue-based reference model.
module tb_trace_packet_arbiter;
  localparam int DEPTH = 16;
  localparam int MAX_STREAK = 8;
  logic mclk = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int failed = 0;
  trace_packet_arbiter_if #(.DEPTH(DEPTH)) bus();
  trace_packet_arbiter #(.DEPTH(DEPTH), .MAX_STREAK(MAX_STREAK), .ECHO_ADDR(16'h0002)) dut (
    .mclk    (mclk),
    .reset_n (reset_n),
    .bus     (bus)
  );
  always #5 mclk = ~mclk;
  logic [31:0] mq[$];
  logic [31:0] exp_q[$];
  bit          dpend, epend, m_strobe, mfull, mempty, ge, pe;
  logic [15:0] dcnt, dtot, edata;
  int          streak;
  logic [31:0] last;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: the FIFO is a plain queue, decisions follow the stream rules directly.
  always @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete(); exp_q.delete();
      dpend = 0; epend = 0; m_strobe = 0;
      dcnt = 0; dtot = 0; edata = 0; streak = 0;
    end else begin
      mfull = mq.size() == DEPTH;
      mempty = mq.size() == 0;
      ge = bus.out_ready && epend && (mempty || streak == MAX_STREAK);
      pe = bus.out_ready && !ge && !mempty;
      m_strobe = ge || pe;
      if (ge) begin
        exp_q.push_back({16'hFFFE, edata});
        epend = 0;
        streak = 0;
      end else if (pe) begin
        exp_q.push_back(mq.pop_front());
        if (streak < MAX_STREAK) streak++;
      end else if (bus.out_ready) streak = 0;
      if (bus.config_strobe && bus.config_addr == 16'h0002) begin
        epend = 1;
        edata = bus.config_data;
      end
      if (dpend && !mfull) begin
        mq.push_back({16'hFFFF, dcnt});
        if (bus.trace_strobe) begin
          dcnt = 1;
          if (dtot != 16'hFFFF) dtot++;
        end else begin
          dcnt = 0;
          dpend = 0;
        end
      end else if (bus.trace_strobe && mfull) begin
        dpend = 1;
        if (dcnt != 16'hFFFF) dcnt++;
        if (dtot != 16'hFFFF) dtot++;
      end else if (bus.trace_strobe) mq.push_back(bus.trace_data);
    end
  end
  // Monitor: per-cycle status plus scoreboard pop on every output strobe.
  always @(negedge mclk) begin
    if (!reset_n) last = '0;
    chk("out_strobe", 32'(bus.out_strobe), 32'(m_strobe));
    chk("fifo_level", 32'(bus.fifo_level), 32'(mq.size()));
    chk("drop_total", 32'(bus.drop_total), 32'(dtot));
    if (bus.out_strobe) begin
      chk("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("out_data", bus.out_data, exp_q.pop_front());
      last = bus.out_data;
    end else chk("out_data_hold", bus.out_data, last);
  end
  task automatic drive(input bit ts, input bit rdy, input bit cs = 0,
                       input logic [15:0] ca = 16'h0002, input logic [15:0] cd = 16'h0000);
    @(negedge mclk);
    bus.trace_strobe  = ts;
    bus.trace_data    = $urandom;
    bus.out_ready     = rdy;
    bus.config_strobe = cs;
    bus.config_addr   = ca;
    bus.config_data   = cd;
  endtask
  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, rdy);
  endtask
  int sp[4] = '{100, 90, 60, 100};
  int rp[4] = '{100, 30, 80, 50};
  int ep[4] = '{3, 10, 20, 5};
  initial begin
    bus.trace_strobe = 0; bus.trace_data = 0; bus.out_ready = 0;
    bus.config_strobe = 0; bus.config_addr = 0; bus.config_data = 0;
    repeat (3) @(negedge mclk);
    chk("rst_out_strobe", 32'(bus.out_strobe), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_fifo_level", 32'(bus.fifo_level), 32'd0);
    chk("rst_drop_total", 32'(bus.drop_total), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) drive(1, 1);
    idle(5, 1);
    for (int i = 0; i < 20; i++) drive(1, 0);
    drive(0, 1);
    for (int i = 0; i < 5; i++) drive(1, 0);
    idle(30, 1);
    for (int i = 0; i < 30; i++) drive(1, 1, i == 3, 16'h0002, 16'hBEEF);
    idle(5, 1);
    drive(0, 0, 1, 16'h0002, 16'h1234);
    drive(0, 0, 1, 16'h0002, 16'h5678);
    drive(0, 0, 1, 16'h0001, 16'hAAAA);
    idle(6, 1);
    for (int i = 0; i < 16; i++) drive(1, 0);
    drive(1, 1);
    idle(25, 1);
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 400; i++)
        drive($urandom_range(99) < sp[p], $urandom_range(99) < rp[p],
              $urandom_range(99) < ep[p], 16'($urandom_range(2)), 16'($urandom));
    idle(30, 1);
    drive(1, 0, 1, 16'h0002, 16'hCAFE);
    for (int i = 0; i < 6; i++) drive(1, 0);
    drive(0, 1);
    @(posedge mclk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_strobe", 32'(bus.out_strobe), 32'd0);
    chk("arst_fifo_level", 32'(bus.fifo_level), 32'd0);
    chk("arst_drop_total", 32'(bus.drop_total), 32'd0);
    chk("arst_out_data", bus.out_data, 32'd0);
    idle(3, 0);
    @(negedge mclk);
    reset_n = 1'b1;
    idle(10, 1);
    for (int i = 0; i < 200; i++)
      drive($urandom_range(99) < 70, $urandom_range(99) < 60,
            $urandom_range(99) < 10, 16'h0002, 16'($urandom));
    idle(40, 1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
